quadrature_encoder: RTL and testbench
=====================================

# quadrature_encoder

Generates two-phase quadrature (A/B) waveforms from queued step requests, one full detent cycle per step. It is the transmitting counterpart of the rotary wheel decoder and drives emulated rotary-encoder signals into the synchronizer, debouncer and decoder chain for on-board self-test. It can also drive an external quadrature input. Step requests are buffered in a small direction FIFO; the phase FSM drains it at a programmable rate.

## Interface
- `phase_cycles`, default 10000: clock cycles each quarter-phase is held; minimum 1.
- `fifo_depth`, default 4: direction FIFO entries; power of two, minimum 2.
- `pos_width`, default 16: width of the position counter (used only with the macro enabled).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `step_valid`  in  1: step request present.
- `step_left`  in  1: direction of the request; 1 = left (counter-clockwise), 0 = right.
- `step_ready`  out  1: FIFO can accept; a step transfers when `step_valid && step_ready`.
- `quad_a`  out  1: phase A, registered.
- `quad_b`  out  1: phase B, registered.
- `busy`  out  1: high while the FSM is not IDLE or the FIFO is non-empty.
- `step_done`  out  1: one-cycle pulse when a step's final phase completes.
- `position`  out  `pos_width`: signed detent count. Present only with `QUAD_ENC_POSITION_EN`.

## Operation
- FSM states are IDLE, PH1, PH2, PH3 and PH4. `{quad_a, quad_b}` is decoded from the state and the latched direction, then registered.
- Right step sequence: PH1=10, PH2=11, PH3=01, PH4=00 (A leads B).
- Left step sequence: PH1=01, PH2=11, PH3=10, PH4=00 (B leads A).
- IDLE drives 00. Successive patterns differ in exactly one bit (Gray), so no glitches occur.
- IDLE with FIFO non-empty: pop the head, latch its direction, enter PH1.
- Each PHn is held `phase_cycles` cycles by a down-counter of width `$clog2(phase_cycles+1)`. The counter reloads on every state entry.
- PH4 expiry:
  - `step_done` is high during the last PH4 cycle.
  - If the FIFO is non-empty, pop and go directly to PH1 with no IDLE cycle. Otherwise go to IDLE.
- FIFO:
  - `step_ready = !full`, registered from the occupancy count.
  - No pass-through: when full, a push and a pop in the same cycle still refuse the push.
  - A push and a pop in the same cycle when not full are both performed; occupancy is unchanged.
- Order is strictly FIFO. Directions are never merged or cancelled.
- A push while IDLE and empty is visible to the FSM on the next edge.

## Timing
- Reset values: `quad_a`=0, `quad_b`=0, `step_ready`=1, `busy`=0, `step_done`=0, `position`=0. The FIFO is emptied and the FSM goes to IDLE.
- A mid-step reset forces 00 immediately, with no completion pulse.
- Latency: request accepted at edge E0 → PH1 pattern appears after edge E1. Each step lasts 4×`phase_cycles` cycles.
- With `phase_cycles`=P, the step accepted at E0 from idle:
  - PH1 spans E1..E1+P.
  - PH4 starts at E1+3P.
  - `step_done` is high in the cycle preceding edge E1+4P.
  - The FSM reaches IDLE, or the next PH1, at E1+4P.
- `busy` falls on the same edge IDLE is entered with an empty FIFO.

## Configuration
- `QUAD_ENC_POSITION_EN` defined:
  - `position` port and register are present.
  - +1 on the `step_done` edge of a right step, −1 for a left step.
  - Two's-complement wrap at `pos_width`; no saturation.
- Macro undefined: the port and register are absent, and all other behaviour is identical.

## Structure
- Package `quad_enc_pkg`:
  - FSM state localparams (IDLE, PH1..PH4).
  - Direction constants `DIR_RIGHT`=0, `DIR_LEFT`=1.
  - The 2-bit phase-pattern constants for both directions.
- Sub-module `step_fifo`: a 1-bit-wide synchronous FIFO, `fifo_depth` entries, with full/empty flags and the same clock and reset. The top contains the FSM, phase counter, output registers and optional position counter.

## Test plan
- Reset (P=4): assert `rst`=0 mid-run → `{a,b}`=00, `step_ready`=1, `busy`=0 immediately; FIFO empty after release.
- Single right step (P=4) accepted at E0 → AB = 10, 11, 01, 00, each for 4 cycles from E1; `step_done` high in the cycle before E17; `busy` low at E17.
- Single left step (P=4) → AB = 01, 11, 10, 00; only one bit toggles per transition.
- Back-to-back R,R,L,L,R pushed on consecutive cycles from idle (depth 4):
  - First request popped at E1; `step_ready` low once requests 2–5 fill the FIFO.
  - `step_ready` returns high after the first pop from the full FIFO.
  - Output order is R,R,L,L,R with no IDLE gap; exactly 5 `step_done` pulses.
- Reset asserted during PH2 of the second of three queued steps → outputs 00 immediately, no further `step_done`, `busy`=0.
- With `QUAD_ENC_POSITION_EN`:
  - 3 right then 1 left → `position`=2.
  - From reset, 1 left → `position`=16'hFFFF.

Source files
------------

// File: rtl/quad_enc_pkg.sv
// Shared types and constants for the quadrature encoder: FSM states, directions and phase patterns.
package quad_enc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPh1,
    StPh2,
    StPh3,
    StPh4
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Patterns are {A, B}.
  localparam logic [1:0] PAT_IDLE  = 2'b00;
  localparam logic [1:0] PAT_R_PH1 = 2'b10;
  localparam logic [1:0] PAT_R_PH2 = 2'b11;
  localparam logic [1:0] PAT_R_PH3 = 2'b01;
  localparam logic [1:0] PAT_L_PH1 = 2'b01;
  localparam logic [1:0] PAT_L_PH2 = 2'b11;
  localparam logic [1:0] PAT_L_PH3 = 2'b10;
  localparam logic [1:0] PAT_PH4   = 2'b00;

  function automatic logic [1:0] phase_pattern(input state_e st, input logic dir);
    logic [1:0] pat;
    pat = PAT_IDLE;
    unique case (st)
      StIdle:  pat = PAT_IDLE;
      StPh1:   pat = (dir == DIR_LEFT) ? PAT_L_PH1 : PAT_R_PH1;
      StPh2:   pat = (dir == DIR_LEFT) ? PAT_L_PH2 : PAT_R_PH2;
      StPh3:   pat = (dir == DIR_LEFT) ? PAT_L_PH3 : PAT_R_PH3;
      StPh4:   pat = PAT_PH4;
      default: pat = PAT_IDLE;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/step_fifo.sv
// 1-bit-wide synchronous FIFO holding queued step directions; full/empty derived from occupancy.
module step_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];

  // A full FIFO refuses the push even if a pop frees a slot this cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/quadrature_encoder.sv
// Quadrature A/B generator draining a direction FIFO, one detent cycle per step.
// Optional signed detent position counter enabled by QUAD_ENC_POSITION_EN.
module quadrature_encoder
  import quad_enc_pkg::*;
#(
  parameter int unsigned PhaseCycles = 10000,
  parameter int unsigned FifoDepth   = 4
`ifdef QUAD_ENC_POSITION_EN
  ,
  parameter int unsigned PosWidth    = 16
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic step_valid_i,
  input  logic step_left_i,
  output logic step_ready_o,
  output logic quad_a_o,
  output logic quad_b_o,
  output logic busy_o,
  output logic step_done_o
`ifdef QUAD_ENC_POSITION_EN
  ,
  output logic signed [PosWidth-1:0] position_o
`endif
);

  localparam int unsigned CntW = $clog2(PhaseCycles + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(PhaseCycles);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic [1:0]      quad_q, quad_d;
  logic            fifo_pop, fifo_head, fifo_full, fifo_empty;
  logic            expire, done;

  step_fifo #(
    .Depth(FifoDepth)
  ) u_step_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (step_valid_i),
    .data_i (step_left_i),
    .pop_i  (fifo_pop),
    .data_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign expire = (cnt_q == CntW'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    fifo_pop = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          dir_d    = fifo_head;
          state_d  = StPh1;
        end
      end
      StPh1: if (expire) state_d = StPh2;
      StPh2: if (expire) state_d = StPh3;
      StPh3: if (expire) state_d = StPh4;
      StPh4: begin
        if (expire) begin
          done = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            dir_d    = fifo_head;
            state_d  = StPh1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Every state entry (including PH4 -> PH1) reloads the hold counter.
    if (state_d != state_q || fifo_pop) begin
      cnt_d = CntLoad;
    end else if (state_q != StIdle) begin
      cnt_d = cnt_q - CntW'(1);
    end
    // Decode from next state so the pattern lands on the same edge as the state.
    quad_d = phase_pattern(state_d, dir_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      quad_q  <= PAT_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      quad_q  <= quad_d;
    end
  end

  assign quad_a_o     = quad_q[1];
  assign quad_b_o     = quad_q[0];
  assign step_ready_o = !fifo_full;
  assign busy_o       = (state_q != StIdle) || !fifo_empty;
  assign step_done_o  = done;

`ifdef QUAD_ENC_POSITION_EN
  logic signed [PosWidth-1:0] pos_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q <= '0;
    end else if (done) begin
      pos_q <= (dir_q == DIR_LEFT) ? pos_q - PosWidth'(1) : pos_q + PosWidth'(1);
    end
  end

  assign position_o = pos_q;
`endif

endmodule

// File: tb/tb_quadrature_encoder.sv
// Self-checking bench for quadrature_encoder: directed and random step bursts against a timeline model.
module tb_quadrature_encoder;

  localparam int P  = 4;
  localparam int D  = 4;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst_ni;
  logic step_valid;
  logic step_left;
  logic step_ready;
  logic quad_a;
  logic quad_b;
  logic busy;
  logic step_done;
`ifdef QUAD_ENC_POSITION_EN
  logic signed [PW-1:0] position;
`endif

  int total = 0;
  int bad   = 0;
  logic dirs[8];
  logic [PW-1:0] exp_pos = '0;
  logic [1:0] pat_r[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] pat_l[4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  quadrature_encoder #(
    .PhaseCycles(P),
    .FifoDepth  (D)
`ifdef QUAD_ENC_POSITION_EN
    ,
    .PosWidth   (PW)
`endif
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .step_valid_i(step_valid),
    .step_left_i (step_left),
    .step_ready_o(step_ready),
    .quad_a_o    (quad_a),
    .quad_b_o    (quad_b),
    .busy_o      (busy),
    .step_done_o (step_done)
`ifdef QUAD_ENC_POSITION_EN
    ,
    .position_o  (position)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ab"}, 32'({quad_a, quad_b}), 32'd0);
    chk({tag, "_ready"}, 32'(step_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(step_done), 32'd0);
`ifdef QUAD_ENC_POSITION_EN
    chk({tag, "_pos"}, 32'(position), 32'(exp_pos));
`endif
  endtask

  // Push dirs[0..n-1] on consecutive edges from idle and follow the whole timeline:
  // step s occupies cycles k = 4P*s .. 4P*s+4P-1 counted from the first edge after acceptance.
  task automatic run_burst(input int n, input int stop_c);
    int span;
    int k, s, ph, pushes, pops, occ;
    logic [1:0] exp_ab;
    logic exp_done, exp_busy;
    span = 4 * P * n;
    step_valid = 1'b1;
    step_left  = dirs[0];
    for (int c = 0; c <= span + 2; c++) begin
      tick();
      step_valid = (c + 1 < n);
      step_left  = (c + 1 < n) ? dirs[c+1] : 1'b0;
      k = c - 1;
      exp_ab   = 2'b00;
      exp_done = 1'b0;
      if (c >= 1 && k < span) begin
        s  = k / (4 * P);
        ph = (k % (4 * P)) / P;
        exp_ab   = dirs[s] ? pat_l[ph] : pat_r[ph];
        exp_done = ((k % (4 * P)) == 4 * P - 1);
      end
      exp_busy = (c < 1 + span);
      pushes = (c + 1 < n) ? c + 1 : n;
      pops   = (c >= 1) ? (((c - 1) / (4 * P) + 1 < n) ? (c - 1) / (4 * P) + 1 : n) : 0;
      occ    = pushes - pops;
      chk("ab", 32'({quad_a, quad_b}), 32'(exp_ab));
      chk("done", 32'(step_done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("ready", 32'(step_ready), 32'(occ < D));
`ifdef QUAD_ENC_POSITION_EN
      chk("pos", 32'(position), 32'(exp_pos));
      if (exp_done) exp_pos = dirs[s] ? exp_pos - 1'b1 : exp_pos + 1'b1;
`endif
      if (c == stop_c) begin
        step_valid = 1'b0;
        return;
      end
    end
    step_valid = 1'b0;
  endtask

  initial begin
    int n, stop_c;
    rst_ni     = 1'b0;
    step_valid = 1'b0;
    step_left  = 1'b0;
    #1;
    chk_idle("reset");
    tick();
    tick();
    #3 rst_ni = 1'b1;
    tick();
    chk_idle("after_reset");

    // Single left from reset: position should wrap to all ones.
    dirs[0] = 1'b1;
    run_burst(1, -1);
    chk_idle("left_end");

    // Single right.
    dirs[0] = 1'b0;
    run_burst(1, -1);

    // Back-to-back R,R,L,L,R filling the FIFO.
    dirs[0] = 1'b0; dirs[1] = 1'b0; dirs[2] = 1'b1; dirs[3] = 1'b1; dirs[4] = 1'b0;
    run_burst(5, -1);
    chk_idle("burst_end");

    // Random bursts.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) dirs[i] = 1'($urandom_range(0, 1));
      run_burst(n, -1);
    end

    // Three queued steps, reset during PH2 of the second.
    for (int i = 0; i < 3; i++) dirs[i] = 1'($urandom_range(0, 1));
    stop_c = 1 + 4 * P + P + $urandom_range(0, P - 1);
    run_burst(3, stop_c);
    #2 rst_ni = 1'b0;
    #1;
    exp_pos = '0;
    chk_idle("midreset");
    tick();
    #3 rst_ni = 1'b1;
    for (int i = 0; i < 3 * P; i++) begin
      tick();
      chk_idle("post_reset");
    end

    // FIFO must have been emptied: a fresh right step runs alone.
    dirs[0] = 1'b0;
    run_burst(1, -1);
    chk_idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
